// File: rtl/hyperbus_ctrl.sv
// HyperBus transaction controller.
// Takes single-word read/write requests from the bridge FIFO and sequences
// the command/address, latency, data and read-write-recovery phases on a
// word-wide pre-DDR PHY interface. Every output is driven from a register
// loaded with the value that belongs to the next state.
module hyperbus_ctrl #(
   parameter int LATENCY    = 6,   // LAT clocks for single latency
   parameter int RD_TIMEOUT = 32,  // max RD clocks before abort
   parameter int T_RWR      = 4    // CS# high clocks after each transaction
) (
   input  logic        hbus_clk,
   input  logic        hbus_rst_n,
   // request side
   input  logic [31:0] adr_i,
   input  logic [15:0] dat_i,
   input  logic [1:0]  mask_i,
   input  logic        rrq,
   input  logic        wrq,
   output logic [15:0] dat_o,
   output logic        ready,
   output logic        valid,
   output logic        err,
   output logic        busy,
   // PHY side
   output logic        phy_cs_n,
   output logic        phy_ck_en,
   output logic [15:0] phy_dq_o,
   output logic        phy_dq_oe,
   output logic [1:0]  phy_rwds_o,
   output logic        phy_rwds_oe,
   input  logic [1:0]  phy_rwds_i,
   input  logic [15:0] phy_dq_i,
   input  logic        phy_rd_valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_CA0, S_CA1, S_CA2, S_LAT, S_WR, S_RD, S_RWR
   } state_t;

   // One shared down-counter serves LAT, RD timeout and RWR; size it for the
   // longest of the three.
   localparam int LAT_MAX   = 2 * LATENCY - 1;
   localparam int CNT_MAX_A = (LAT_MAX > RD_TIMEOUT - 1) ? LAT_MAX : RD_TIMEOUT - 1;
   localparam int CNT_MAX   = (CNT_MAX_A > T_RWR - 1) ? CNT_MAX_A : T_RWR - 1;
   localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   typedef logic [CNT_W-1:0] cnt_t;

   localparam cnt_t LAT_SINGLE = cnt_t'(LATENCY - 1);
   localparam cnt_t LAT_DOUBLE = cnt_t'(2 * LATENCY - 1);
   localparam cnt_t RD_LOAD    = cnt_t'(RD_TIMEOUT - 1);
   localparam cnt_t RWR_LOAD   = cnt_t'(T_RWR - 1);
   localparam cnt_t CNT_ONE    = cnt_t'(1);

   // control state
   state_t      state_q, state_d;
   cnt_t        cnt_q, cnt_d;

   // latched transaction payload
   logic [31:0] adr_q;
   logic [15:0] dat_q;
   logic [1:0]  mask_q;
   logic        rd_q;
   logic        dbl_q;

   // registered outputs
   logic [15:0] dat_o_q, dat_o_d;
   logic        ready_q, ready_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
   logic        cs_n_q, cs_n_d;
   logic        ck_en_q, ck_en_d;
   logic [15:0] dq_o_q, dq_o_d;
   logic        dq_oe_q, dq_oe_d;
   logic [1:0]  rwds_o_q, rwds_o_d;
   logic        rwds_oe_q, rwds_oe_d;

   // CA word source: while IDLE the request is still on the inputs, so CA0
   // must be built from them to appear one clock after the request.
   logic [31:0] ca_adr;
   logic        ca_rd;
   logic [47:0] ca;

   // Next-state, counter and pulse-output logic.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = 1'b0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      dat_o_d = dat_o_q;

      case (state_q)
         S_IDLE: begin
            if (wrq || rrq) state_d = S_CA0;
         end
         S_CA0: state_d = S_CA1;
         S_CA1: state_d = S_CA2;
         S_CA2: begin
            state_d = S_LAT;
            cnt_d   = dbl_q ? LAT_DOUBLE : LAT_SINGLE;
         end
         S_LAT: begin
            if (cnt_q == '0) begin
               if (rd_q) begin
                  state_d = S_RD;
                  cnt_d   = RD_LOAD;
               end else begin
                  state_d = S_WR;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_WR: begin
            state_d = S_RWR;
            cnt_d   = RWR_LOAD;
            ready_d = 1'b1;
         end
         S_RD: begin
            // Data arriving on the last timeout clock still counts as valid.
            if (phy_rd_valid) begin
               state_d = S_RWR;
               cnt_d   = RWR_LOAD;
               valid_d = 1'b1;
               dat_o_d = phy_dq_i;
            end else if (cnt_q == '0) begin
               state_d = S_RWR;
               cnt_d   = RWR_LOAD;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_RWR: begin
            if (cnt_q == '0) state_d = S_IDLE;
            else             cnt_d   = cnt_q - CNT_ONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // PHY and status outputs decoded from the state about to be entered.
   always_comb begin
      ca_adr = (state_q == S_IDLE) ? adr_i : adr_q;
      ca_rd  = (state_q == S_IDLE) ? ~wrq  : rd_q;
      ca     = {ca_rd, 1'b0, 1'b1, ca_adr[31:3], 13'd0, ca_adr[2:0]};

      busy_d    = (state_d != S_IDLE);
      cs_n_d    = (state_d == S_IDLE) || (state_d == S_RWR);
      ck_en_d   = ~cs_n_d;
      dq_o_d    = 16'h0000;
      dq_oe_d   = 1'b0;
      rwds_o_d  = 2'b00;
      rwds_oe_d = 1'b0;

      case (state_d)
         S_CA0: begin
            dq_o_d  = ca[47:32];
            dq_oe_d = 1'b1;
         end
         S_CA1: begin
            dq_o_d  = ca[31:16];
            dq_oe_d = 1'b1;
         end
         S_CA2: begin
            dq_o_d  = ca[15:0];
            dq_oe_d = 1'b1;
         end
         S_WR: begin
            dq_o_d    = dat_q;
            dq_oe_d   = 1'b1;
            rwds_o_d  = mask_q;
            rwds_oe_d = 1'b1;
         end
         default: ;
      endcase
   end

   // State, counter and output registers with synchronous reset.
   always_ff @(posedge hbus_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!hbus_rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         dat_o_q   <= 16'h0000;
         ready_q   <= 1'b0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         ck_en_q   <= 1'b0;
         dq_o_q    <= 16'h0000;
         dq_oe_q   <= 1'b0;
         rwds_o_q  <= 2'b00;
         rwds_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dat_o_q   <= dat_o_d;
         ready_q   <= ready_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         cs_n_q    <= cs_n_d;
         ck_en_q   <= ck_en_d;
         dq_o_q    <= dq_o_d;
         dq_oe_q   <= dq_oe_d;
         rwds_o_q  <= rwds_o_d;
         rwds_oe_q <= rwds_oe_d;
      end
   end

   // Capture the request payload and sample the latency request in CA0.
   always_ff @(posedge hbus_clk) begin
      // NOTE: payload registers carry no reset; each is written before the
      // control path ever reads it, so a reset would only cost routing.
      if (state_q == S_IDLE && (wrq || rrq)) begin
         adr_q  <= adr_i;
         dat_q  <= dat_i;
         mask_q <= mask_i;
         rd_q   <= ~wrq;
      end
      if (state_q == S_CA0) begin
         dbl_q <= |phy_rwds_i;
      end
   end

   assign dat_o       = dat_o_q;
   assign ready       = ready_q;
   assign valid       = valid_q;
   assign err         = err_q;
   assign busy        = busy_q;
   assign phy_cs_n    = cs_n_q;
   assign phy_ck_en   = ck_en_q;
   assign phy_dq_o    = dq_o_q;
   assign phy_dq_oe   = dq_oe_q;
   assign phy_rwds_o  = rwds_o_q;
   assign phy_rwds_oe = rwds_oe_q;

endmodule

// File: doc/hyperbus_ctrl.md
# hyperbus_ctrl

HyperBus transaction controller sitting directly downstream of the Wishbone-to-HyperBus bridge's FIFO. It consumes single-word read/write requests on the `hbus_*` request interface and drives the HyperBus command/address, latency, data and recovery phases. Its pin side is a word-wide, pre-DDR PHY interface. Everything runs in the `hbus_clk` domain.

## Interface
- `LATENCY`, 6: clocks spent in LAT state when the device requests single latency (≥1).
- `RD_TIMEOUT`, 32: maximum clocks waiting for read data before abort (≥2).
- `T_RWR`, 4: clocks CS# held high after every transaction (≥1).

- `hbus_clk` in 1: sole clock.
- `hbus_rst_n` in 1: reset, synchronous and active-low.
- `adr_i` in 32: HyperBus word address.
- `dat_i` in 16: write data.
- `mask_i` in 2: byte mask; bit=1 means the byte is NOT written. `[1]` = `dat_i[15:8]`.
- `rrq` in 1: read request, single-cycle pulse.
- `wrq` in 1: write request, single-cycle pulse.
- `dat_o` out 16: read data, valid with `valid`.
- `ready` out 1: one-cycle pulse, write committed.
- `valid` out 1: one-cycle pulse, read data on `dat_o`.
- `err` out 1: one-cycle pulse, read timeout.
- `busy` out 1: transaction in progress.
- `phy_cs_n` out 1: chip select.
- `phy_ck_en` out 1: enables CK toggling.
- `phy_dq_o` out 16: `[15:8]` is the rising-edge byte; `[7:0]` is the falling-edge byte.
- `phy_dq_oe` out 1: DQ drive enable.
- `phy_rwds_o` out 2: RWDS per edge, same split as DQ.
- `phy_rwds_oe` out 1: RWDS drive enable.
- `phy_rwds_i` in 2: sampled RWDS.
- `phy_dq_i` in 16: captured read word.
- `phy_rd_valid` in 1: `phy_dq_i` holds a captured word this cycle.

## Operation
- States: IDLE, CA0, CA1, CA2, LAT, WR, RD, RWR.
- IDLE:
  - On `wrq` or `rrq`, latch `adr_i`, `dat_i`, `mask_i` and the request type, then go to CA0.
  - If both are high, write wins and the read is dropped.
  - Requests arriving outside IDLE are ignored; no queueing.
- CA word: CA[47]=1 for read and 0 for write. CA[46]=0 (memory space). CA[45]=1 (linear burst). CA[44:16]=adr[31:3]. CA[15:3]=0. CA[2:0]=adr[2:0].
- CA0/CA1/CA2 drive CA[47:32], CA[31:16] and CA[15:0] respectively on `phy_dq_o`, with `phy_dq_oe`=1.
- `phy_rwds_i` is sampled in CA0. If either bit is 1, latch double latency.
- LAT:
  - Counter loaded with LATENCY-1, or 2·LATENCY-1 when double latency is latched.
  - Decrement each clock; `phy_dq_oe`=0.
  - On reaching 0, go to WR or RD.
- WR (1 clock):
  - `phy_dq_o`=latched data, `phy_dq_oe`=1.
  - `phy_rwds_o`=latched mask, `phy_rwds_oe`=1.
  - Go to RWR and pulse `ready`.
- RD:
  - Timeout counter loaded with RD_TIMEOUT-1.
  - On `phy_rd_valid`: register `phy_dq_i` into `dat_o`, pulse `valid`, go to RWR.
  - If the counter hits 0 first: pulse `err`, go to RWR, leave `dat_o` unchanged.
  - `phy_rd_valid` arriving in the same cycle as the counter hitting 0 counts as valid, not error.
- RWR:
  - `phy_cs_n`=1, `phy_ck_en`=0, all output enables 0.
  - Hold for T_RWR clocks, then go to IDLE.
- `phy_cs_n`=0 and `phy_ck_en`=1 from CA0 through the last WR/RD cycle inclusive.
- `phy_rwds_oe`=1 only in WR.
- `busy`=1 in every state except IDLE.
- Reset:
  - Any cycle with `hbus_rst_n`=0 forces IDLE, including mid-transaction.
  - The transaction is abandoned with no `ready`, `valid` or `err`.
  - Reset values: `phy_cs_n`=1. 0 for `phy_ck_en`, all output enables, `phy_dq_o`, `phy_rwds_o`, `dat_o`, `ready`, `valid`, `err` and `busy`.

## Timing
- All outputs are registered.
- Request sampled at edge 0 → CA0 outputs and `busy`=1 at cycle 1; CA1 at cycle 2; CA2 at cycle 3.
- LAT occupies cycles 4 … 3+L, where L = LATENCY or 2·LATENCY.
- WR is at cycle 4+L. `ready` pulses at cycle 5+L, coincident with the first RWR cycle.
- RD starts at cycle 4+L. If `phy_rd_valid` is sampled at edge k, `valid` and `dat_o` appear in cycle k+1, which is also the first RWR cycle.
- `busy` falls in cycle 5+L+T_RWR for writes.
- Earliest next request is accepted on the edge where `busy`=0 is first visible.
- Write total: 4+L+1+T_RWR clocks; default 15 with single latency.

## Test plan
- Write, single latency: `wrq`, adr=0x0000_1235, dat=0xA55A, mask=2'b00, `phy_rwds_i`=0.
  - CA words 0x2000, 0x0246, 0x0005.
  - 6 LAT cycles, then WR drives 0xA55A with RWDS 00.
  - `ready` at cycle 11; `busy` low at cycle 15.
- Write, double latency: `phy_rwds_i`=2'b11 during CA0, mask=2'b10 → 12 LAT cycles; WR drives RWDS 10; `ready` at cycle 17.
- Read: `rrq`, adr=0x10; `phy_rd_valid` on the 3rd RD cycle with `phy_dq_i`=0xBEEF.
  - CA0=0xA000.
  - `valid` for 1 cycle with `dat_o`=0xBEEF; `err`=0.
- Timeout: `rrq` with `phy_rd_valid` never asserted.
  - `err` pulses exactly 32 clocks after RD entry.
  - `valid`=0; `dat_o` keeps its previous value; CS# high for 4 cycles.
- Arbitration:
  - `wrq` and `rrq` asserted together → only a write is issued.
  - `rrq` pulsed mid-transaction → ignored, no second CA.
  - New request on the first `busy`=0 cycle → accepted.
- Reset during LAT:
  - `hbus_rst_n`=0 for 1 cycle → next cycle `phy_cs_n`=1, `busy`=0, no `ready`.
  - A subsequent write completes normally.
